// File: rtl/radix2_signed_divider_pkg.sv
// Shared types and helpers for the radix-2 signed divider.
// abs_ext works on a 64-bit sign-extended operand, so WIDTH must be <= 64.
package radix2_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        FIX
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam int unsigned DIV_MAX_W = 64;

    // Magnitude with one extra bit so the most negative value stays exact.
    function automatic logic [DIV_MAX_W:0] abs_ext(input logic [DIV_MAX_W-1:0] x);
        logic [DIV_MAX_W:0] ext;
        ext = {x[DIV_MAX_W-1], x};
        return x[DIV_MAX_W-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/radix2_signed_divider_if.sv
// Start/operand/result bundle between a controller and the divider.
interface radix2_signed_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic [WIDTH-1:0] outQuotient;
    logic [WIDTH-1:0] outRemainder;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic             overflow;

    modport master (
        output start, inputA, inputB,
        input  outQuotient, outRemainder, busy, done, divByZero, overflow
    );

    modport slave (
        input  start, inputA, inputB,
        output outQuotient, outRemainder, busy, done, divByZero, overflow
    );
endinterface

// File: rtl/radix2_signed_divider_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module radix2_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH:0]   div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0] shifted;

    // Partial remainder stays below |B| <= 2^(WIDTH-1), so WIDTH bits hold it.
    always_comb begin
        shifted = {rem_i, bit_i};
        if (shifted >= div_i) begin
            rem_o  = WIDTH'(shifted - div_i);
            qbit_o = 1'b1;
        end else begin
            rem_o  = WIDTH'(shifted);
            qbit_o = 1'b0;
        end
    end
endmodule

// File: rtl/radix2_signed_divider.sv
// Sequential signed divider: restoring radix-2 on magnitudes, then sign fix-up.
// Optional macro DIV_BYPASS_EN: divisors 0, +1, -1 skip the iteration phase.
module radix2_signed_divider
    import radix2_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    radix2_signed_divider_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             dz_q, dz_d, ov_q, ov_d;
    logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
    logic             done_q, done_d, dzo_q, dzo_d, ovo_q, ovo_d;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             b_zero;

    assign abs_a  = WIDTH'(abs_ext(DIV_MAX_W'($signed(a_q))));
    assign abs_b  = (WIDTH+1)'(abs_ext(DIV_MAX_W'($signed(b_q))));
    assign b_zero = (b_q == '0);

`ifdef DIV_BYPASS_EN
    logic b_unit;
    assign b_unit = (abs_b == (WIDTH+1)'(1));
`endif

    radix2_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (sh_q[WIDTH-1]),
        .div_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Next-state and datapath: sh_q shifts dividend bits out and quotient bits in.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
        ovo_d   = ovo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.inputA;
                    b_d     = bus.inputB;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_d    = abs_a;
                dvs_d   = abs_b;
                rem_d   = '0;
                qneg_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                rneg_d  = a_q[WIDTH-1];
                dz_d    = b_zero;
                ov_d    = (a_q == MIN_VAL) && (b_q == '1);
                cnt_d   = CNT_W'(WIDTH-1);
                state_d = ITER;
`ifdef DIV_BYPASS_EN
                // Preload the magnitudes the iterations would have produced.
                if (b_zero) begin
                    rem_d   = abs_a;
                    state_d = FIX;
                end else if (b_unit) begin
                    state_d = FIX;
                end
`endif
            end
            ITER: begin
                rem_d = step_rem;
                sh_d  = {sh_q[WIDTH-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                quot_d  = dz_q ? '1 : (qneg_q ? -sh_q : sh_q);
                remo_d  = rneg_q ? -rem_q : rem_q;
                dzo_d   = dz_q;
                ovo_d   = ov_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dzo_q   <= dzo_d;
            ovo_q   <= ovo_d;
            done_q  <= done_d;
        end
    end

    assign bus.outQuotient  = quot_q;
    assign bus.outRemainder = remo_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.divByZero    = dzo_q;
    assign bus.overflow     = ovo_q;

endmodule

// File: tb/tb_radix2_signed_divider.sv
// Bench for radix2_signed_divider: arithmetic reference model plus literal directed cases.
module tb_radix2_signed_divider;
    localparam int unsigned      W    = 32;
    localparam logic [W-1:0]     MINV = {1'b1, {(W-1){1'b0}}};
`ifdef DIV_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int unsigned  acc_at;
        int unsigned  done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    radix2_signed_divider_if #(.WIDTH(W)) bus ();
    radix2_signed_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned free_at = 0;
    bit          checking = 1'b0;
    exp_t        pend[$];
    exp_t        held;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating division, remainder follows the dividend sign.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.acc_at = 0;
        e.done_at = 0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (a == MINV && b == '1) begin
            e.q  = MINV;
            e.r  = '0;
            e.ov = 1'b1;
        end else begin
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end
        return e;
    endfunction

    function automatic int unsigned lat_of(input logic [W-1:0] b);
        bit triv;
        triv = (b == '0) || (b == W'(1)) || (b == '1);
        return (BYPASS_EN && triv) ? 2 : W + 2;
    endfunction

    // Model of acceptance timing: one operation in flight, FIX-cycle starts ignored.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            pend.delete();
            free_at = 0;
            held.q = '0; held.r = '0; held.dz = 1'b0; held.ov = 1'b0;
            checking = 1'b1;
        end else if (bus.start === 1'b1 && cyc >= free_at) begin
            e = model(bus.inputA, bus.inputB);
            e.acc_at  = cyc;
            e.done_at = cyc + lat_of(bus.inputB);
            pend.push_back(e);
            free_at = e.done_at + 1;
        end
    end

    // Every-cycle compare of done/busy/results against the model.
    always @(negedge clk) begin
        bit exp_done, exp_busy;
        if (checking) begin
            exp_done = (pend.size() > 0) && (pend[0].done_at == cyc);
            if (exp_done) begin
                held = pend[0];
                pend.pop_front();
            end
            exp_busy = (pend.size() > 0) && (cyc >= pend[0].acc_at);
            chk1("done", bus.done, exp_done);
            chk1("busy", bus.busy, exp_busy);
            chk("quotient", bus.outQuotient, held.q);
            chk("remainder", bus.outRemainder, held.r);
            chk1("divByZero", bus.divByZero, held.dz);
            chk1("overflow", bus.overflow, held.ov);
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && bus.busy !== 1'b0; i++) @(negedge clk);
        chk1({name, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eov, input int unsigned elat);
        int unsigned k;
        bit got;
        wait_idle(name);
        bus.inputA = a;
        bus.inputB = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk1({name, "_done"}, got, 1'b1);
        chk({name, "_lat"}, W'(cyc - k), W'(elat));
        chk({name, "_q"}, bus.outQuotient, eq);
        chk({name, "_r"}, bus.outRemainder, er);
        chk1({name, "_dz"}, bus.divByZero, edz);
        chk1({name, "_ov"}, bus.overflow, eov);
    endtask

    // Random operation with stray start pulses early in the iteration phase.
    task automatic run_rand(input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        bit stray_ok;
        wait_idle("rand");
        bus.inputA = a;
        bus.inputB = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        stray_ok = (lat_of(b) > 2);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                bus.start = 1'b0;
            end else begin
                bus.start  = stray_ok && (i < 10) && ($urandom_range(0, 3) == 0);
                bus.inputA = $urandom;
                bus.inputB = $urandom;
            end
        end
        bus.start = 1'b0;
        chk1("rand_done", got, 1'b1);
    endtask

    function automatic logic [W-1:0] pick_a();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s == 0) return MINV;
        if (s == 1) return '0;
        if (s == 2) return W'($urandom_range(0, 200)) - W'(100);
        return W'($urandom);
    endfunction

    function automatic logic [W-1:0] pick_b();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s == 0) return '0;
        if (s == 1) return W'(1);
        if (s == 2) return '1;
        if (s == 3) return W'($urandom_range(0, 40)) - W'(20);
        return W'($urandom);
    endfunction

    initial begin
        int unsigned k;
        bit seen;
        rst = 1'b1;
        bus.start  = 1'b0;
        bus.inputA = '0;
        bus.inputB = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_q", bus.outQuotient, '0);
        chk("reset_r", bus.outRemainder, '0);
        chk1("reset_done", bus.done, 1'b0);
        chk1("reset_busy", bus.busy, 1'b0);

        run_op("big", 32'd464960160, 32'd840, 32'd553524, 32'd0, 1'b0, 1'b0, W + 2);
        run_op("negdvd", -32'sd143362716, 32'd553524, -32'sd259, 32'd0, 1'b0, 1'b0, W + 2);
        run_op("p100m7", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b0, W + 2);
        run_op("m100p7", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0, W + 2);
        run_op("div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, lat_of(32'd0));
        run_op("after0", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, W + 2);
        run_op("ovf", MINV, 32'hFFFF_FFFF, MINV, 32'd0, 1'b0, 1'b1, lat_of(32'hFFFF_FFFF));
        run_op("minby1", MINV, 32'd1, MINV, 32'd0, 1'b0, 1'b0, lat_of(32'd1));
        run_op("zero_dvd", 32'd0, 32'd13, 32'd0, 32'd0, 1'b0, 1'b0, W + 2);
        run_op("bym1", 32'd1234, 32'hFFFF_FFFF, -32'sd1234, 32'd0, 1'b0, 1'b0,
               BYPASS_EN ? 2 : W + 2);
        run_op("by3", 32'd1234, 32'd3, 32'd411, 32'd1, 1'b0, 1'b0, W + 2);

        // Start pulse mid-iteration must be ignored.
        wait_idle("ign");
        bus.inputA = 32'd1000; bus.inputB = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
        repeat (6) @(negedge clk);
        bus.inputA = 32'd9; bus.inputB = 32'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk1("ign_done", seen, 1'b1);
        chk("ign_lat", W'(cyc - k), W'(W + 2));
        chk("ign_q", bus.outQuotient, 32'd333);
        chk("ign_r", bus.outRemainder, 32'd1);

        // Reset in the middle of an operation discards it.
        wait_idle("rst");
        bus.inputA = 32'd1000; bus.inputB = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_q", bus.outQuotient, '0);
        chk("rst_r", bus.outRemainder, '0);
        chk1("rst_busy", bus.busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk1("rst_no_done", seen, 1'b0);
        run_op("fresh", 32'd9, 32'd9, 32'd1, 32'd0, 1'b0, 1'b0, W + 2);

        for (int n = 0; n < 150; n++) begin
            run_rand(pick_a(), pick_b());
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
